// File: rtl/alu_issuer_pkg.sv
// Shared ALU opcode constants, control width and issuer FSM encoding.
package venera_alu_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_OP_NOP = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OP_ADD = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_OP_SUB = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } issuer_state_t;

  function automatic logic op_is_legal(input logic [ALU_CTRL_W-1:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issuer_timeout.sv
// WAIT-state watchdog for alu_issuer; exists only when ALU_TIMEOUT_EN is defined.
// o_expired flags the last WAIT cycle before the count would reach TIMEOUT_CYCLES.
`ifdef ALU_TIMEOUT_EN
module alu_issuer_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= 8'd0;
    end else if (i_count) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/alu_issuer.sv
// Single-outstanding command issuer driving the 8-bit ALU load/valid interface.
// Optional WAIT watchdog enabled by ALU_TIMEOUT_EN; all outputs decode from state or registers.
module alu_issuer
  import venera_alu_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ALU_CTRL_W-1:0] i_cmd_op,
  input  logic [DATA_W-1:0]     i_cmd_a,
  input  logic [DATA_W-1:0]     i_cmd_b,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_alu_load,
  output logic [DATA_W-1:0]     o_alu_din_a,
  output logic [DATA_W-1:0]     o_alu_din_b,
  input  logic                  i_alu_valid,
  input  logic [DATA_W-1:0]     i_alu_dout,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_busy
);

  issuer_state_t         r_state;
  issuer_state_t         w_next;
  logic [ALU_CTRL_W-1:0] r_op;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  logic [DATA_W-1:0]     r_rsp_data;
  logic                  r_rsp_err;
  logic                  w_tmo_expired;

`ifdef ALU_TIMEOUT_EN
  logic w_tmo_clear;
  logic w_tmo_count;

  assign w_tmo_clear = (r_state == ST_ISSUE);
  assign w_tmo_count = (r_state == ST_WAIT) && !i_alu_valid;

  alu_issuer_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_tmo_clear),
    .i_count   (w_tmo_count),
    .o_expired (w_tmo_expired)
  );
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_tmo_expired    = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_cmd_valid) w_next = op_is_legal(i_cmd_op) ? ST_ISSUE : ST_RESP;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (i_alu_valid || w_tmo_expired) w_next = ST_RESP;
      ST_RESP:  if (i_rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Illegal opcodes are latched too, but the ALU lines are gated by state so the ALU never sees them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op       <= ALU_OP_NOP;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_op       <= i_cmd_op;
            r_a        <= i_cmd_a;
            r_b        <= i_cmd_b;
            r_rsp_data <= '0;
            r_rsp_err  <= !op_is_legal(i_cmd_op);
          end
        end
        ST_WAIT: begin
          if (i_alu_valid) begin
            r_rsp_data <= i_alu_dout;
            r_rsp_err  <= 1'b0;
          end else if (w_tmo_expired) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_cmd_ready   = 1'b0;
    o_busy        = 1'b1;
    o_alu_load    = 1'b0;
    o_alu_control = ALU_OP_NOP;
    o_alu_din_a   = '0;
    o_alu_din_b   = '0;
    o_rsp_valid   = 1'b0;
    o_rsp_data    = '0;
    o_rsp_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
      end
      ST_ISSUE: begin
        o_alu_load    = 1'b1;
        o_alu_control = r_op;
        o_alu_din_a   = r_a;
        o_alu_din_b   = r_b;
      end
      ST_WAIT: begin
        o_alu_control = r_op;
        o_alu_din_a   = r_a;
        o_alu_din_b   = r_b;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_data  = r_rsp_data;
        o_rsp_err   = r_rsp_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: ALU stub, timestamp-based transaction model checked every cycle,
// plus directed cases with hand-computed expectations followed by a random phase.
`timescale 1ns/1ps
module tb_alu_issuer;
  import venera_alu_pkg::*;

  localparam int DW  = 8;
  localparam int TMO = 15;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [2:0]    i_cmd_op = 3'd0;
  logic [DW-1:0] i_cmd_a = '0;
  logic [DW-1:0] i_cmd_b = '0;
  logic [2:0]    o_alu_control;
  logic          o_alu_load;
  logic [DW-1:0] o_alu_din_a;
  logic [DW-1:0] o_alu_din_b;
  logic          i_alu_valid = 1'b0;
  logic [DW-1:0] i_alu_dout = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_busy;

  alu_issuer #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_alu_control(o_alu_control), .o_alu_load(o_alu_load),
    .o_alu_din_a(o_alu_din_a), .o_alu_din_b(o_alu_din_b),
    .i_alu_valid(i_alu_valid), .i_alu_dout(i_alu_dout),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- ALU stub ----------------
  int         stub_delay = 1;   // cycles from load to valid; 0 = never answers
  bit         stray_rand = 1'b0;
  bit         stray_ok   = 1'b0;
  int         stray_req  = 0;
  int         stray_ack  = 0;
  int         pend       = 0;
  bit         ld_flag    = 1'b0;
  logic [7:0] ld_res     = '0;

  always @(posedge i_clk) begin
    #1;
    if (ld_flag && stub_delay > 0) pend = stub_delay;
    i_alu_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i_alu_valid = 1'b1;
        i_alu_dout  = ld_res;
      end
    end else if (stray_req != stray_ack) begin
      stray_ack   = stray_req;
      i_alu_valid = 1'b1;
      i_alu_dout  = 8'hAA;
    end else if (stray_rand && stray_ok && $urandom_range(0, 3) == 0) begin
      i_alu_valid = 1'b1;
      i_alu_dout  = 8'($urandom);
    end
  end

  // ---------------- event monitor ----------------
  int         mon_clr = 0, mon_clr_ack = 0;
  int         mon_load_cnt = 0, mon_load_cyc = -1, mon_rsp_cyc = -1;
  bit         mon_seen = 1'b0;
  logic [7:0] mon_rsp_data = '0;
  logic       mon_rsp_err = 1'b0;
  logic [7:0] rsp_q[$];

  always @(negedge i_clk) begin
    if (mon_clr != mon_clr_ack) begin
      mon_clr_ack  = mon_clr;
      mon_load_cnt = 0;
      mon_load_cyc = -1;
      mon_rsp_cyc  = -1;
      mon_seen     = 1'b0;
      rsp_q.delete();
    end
    ld_flag = o_alu_load;
    if (o_alu_load) begin
      mon_load_cnt++;
      mon_load_cyc = cyc;
      ld_res = (o_alu_control == ALU_OP_ADD) ? 8'(o_alu_din_a + o_alu_din_b) :
               (o_alu_control == ALU_OP_SUB) ? 8'(o_alu_din_a - o_alu_din_b) : 8'h00;
    end
    if (o_rsp_valid && !mon_seen) begin
      mon_seen     = 1'b1;
      mon_rsp_cyc  = cyc;
      mon_rsp_data = o_rsp_data;
      mon_rsp_err  = o_rsp_err;
    end
    if (o_rsp_valid && i_rsp_ready) rsp_q.push_back(o_rsp_data);
  end

  // ---------------- transaction model + per-cycle compare ----------------
  // One command at a time; expected outputs follow from accept time and ALU result time.
  bit         m_known = 1'b0, m_inflight = 1'b0, m_legal = 1'b0, m_tmo = 1'b0;
  int         m_acc = 0, m_res = -1;
  logic [2:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0, m_data = '0;
  logic       m_err = 1'b0;

  always @(negedge i_clk) begin
    bit e_rv;
    e_rv = m_inflight && (m_res >= 0) && (cyc >= m_res);
    if (m_known) begin
      chk("cmd_ready", o_cmd_ready, !m_inflight);
      chk("busy", o_busy, m_inflight);
      chk("alu_load", o_alu_load, m_inflight && m_legal && (cyc == m_acc + 1));
      chk("rsp_valid", o_rsp_valid, e_rv);
      if (m_inflight && m_legal && !e_rv) begin
        chk("alu_control", o_alu_control, m_op);
        chk("alu_din_a", o_alu_din_a, m_a);
        chk("alu_din_b", o_alu_din_b, m_b);
      end
      if (e_rv) begin
        chk("rsp_data", o_rsp_data, m_data);
        chk("rsp_err", o_rsp_err, m_err);
      end
    end
    if (i_reset) begin
      m_known    = 1'b1;
      m_inflight = 1'b0;
    end else if (m_known) begin
      if (!m_inflight) begin
        if (i_cmd_valid) begin
          m_inflight = 1'b1;
          m_acc      = cyc;
          m_op       = i_cmd_op;
          m_a        = i_cmd_a;
          m_b        = i_cmd_b;
          m_legal    = (i_cmd_op == 3'd1) || (i_cmd_op == 3'd2);
          m_tmo      = 1'b0;
          if (m_legal) m_res = -1;
          else begin
            m_res  = cyc + 1;
            m_data = 8'h00;
            m_err  = 1'b1;
          end
        end
      end else if (e_rv) begin
        if (i_rsp_ready) begin
          if (m_legal && !m_tmo)
            chk("model_alu", m_data, (m_op == 3'd1) ? 8'(m_a + m_b) : 8'(m_a - m_b));
          m_inflight = 1'b0;
        end
      end else if (m_legal && m_res < 0 && cyc >= m_acc + 2) begin
        if (i_alu_valid) begin
          m_res  = cyc + 1;
          m_data = i_alu_dout;
          m_err  = 1'b0;
        end
`ifdef ALU_TIMEOUT_EN
        else if (cyc - (m_acc + 2) + 1 == TMO) begin
          m_res  = cyc + 1;
          m_data = 8'h00;
          m_err  = 1'b1;
          m_tmo  = 1'b1;
        end
`endif
      end
    end
    stray_ok = !(m_inflight && m_legal && m_res < 0);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_a     = a;
    i_cmd_b     = b;
    for (int k = 0; k < 60; k++) begin
      @(negedge i_clk);
      if (o_cmd_ready) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    tick();
    i_cmd_valid = 1'b0;
    if (!ok) chk("send_accept", 32'd0, 32'd1);
  endtask

  initial begin
    int acc;
    int accs[3];
    bit found;

    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_alu_load", o_alu_load, 0);
    chk("rst_rsp_data", o_rsp_data, 0);

    // add: single load at N+1, response at N+3
    tick();
    i_rsp_ready = 1'b1;
    mon_clr++;
    send(ALU_OP_ADD, 8'h12, 8'h34, acc);
    repeat (6) tick();
    chk("add_load_cnt", mon_load_cnt, 1);
    chk("add_load_at", mon_load_cyc - acc, 1);
    chk("add_rsp_at", mon_rsp_cyc - acc, 3);
    chk("add_data", mon_rsp_data, 8'h46);
    chk("add_err", mon_rsp_err, 0);

    // sub wrap under 5 cycles of backpressure
    i_rsp_ready = 1'b0;
    send(ALU_OP_SUB, 8'h00, 8'h01, acc);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("sub_rsp_found", found, 1);
    chk("sub_rsp_at", cyc - acc, 3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge i_clk);
      chk("sub_hold_valid", o_rsp_valid, 1);
      chk("sub_hold_data", o_rsp_data, 8'hFF);
      chk("sub_hold_err", o_rsp_err, 0);
      chk("sub_hold_cmd_ready", o_cmd_ready, 0);
    end
    tick();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("sub_hs_valid", o_rsp_valid, 1);
    chk("sub_hs_cmd_ready", o_cmd_ready, 0);
    @(negedge i_clk);
    chk("sub_post_cmd_ready", o_cmd_ready, 1);
    chk("sub_post_valid", o_rsp_valid, 0);

    // illegal opcode: no ALU load, error response at N+1
    tick();
    mon_clr++;
    send(3'b011, 8'h55, 8'h00, acc);
    repeat (4) tick();
    chk("ill_load_cnt", mon_load_cnt, 0);
    chk("ill_rsp_at", mon_rsp_cyc - acc, 1);
    chk("ill_data", mon_rsp_data, 8'h00);
    chk("ill_err", mon_rsp_err, 1);

    // reset while waiting on the ALU, then a stray ALU strobe
    stub_delay = 0;
    send(ALU_OP_ADD, 8'h01, 8'h02, acc);
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rstmid_cmd_ready", o_cmd_ready, 1);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_rsp_valid", o_rsp_valid, 0);
    tick();
    stray_req++;
    repeat (3) begin
      @(negedge i_clk);
      chk("stray_busy", o_busy, 0);
      chk("stray_rsp_valid", o_rsp_valid, 0);
    end

    // ALU never answers
    tick();
    mon_clr++;
    send(ALU_OP_ADD, 8'h03, 8'h04, acc);
    repeat (TMO + 8) tick();
`ifdef ALU_TIMEOUT_EN
    chk("tmo_rsp_at", mon_rsp_cyc - acc, TMO + 2);
    chk("tmo_data", mon_rsp_data, 8'h00);
    chk("tmo_err", mon_rsp_err, 1);
`else
    chk("hang_busy", o_busy, 1);
    chk("hang_no_rsp", mon_seen, 0);
`endif
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;

    // back-to-back with valid and ready held high
    stub_delay = 1;
    tick();
    mon_clr++;
    i_cmd_valid = 1'b1;
    i_cmd_op = ALU_OP_ADD; i_cmd_a = 8'h10; i_cmd_b = 8'h01;
    for (int n = 0; n < 3; n++) begin
      found   = 1'b0;
      accs[n] = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge i_clk);
        if (o_cmd_ready) begin
          found   = 1'b1;
          accs[n] = cyc;
          break;
        end
      end
      chk("b2b_accept", found, 1);
      tick();
      if (n == 0) begin
        i_cmd_op = ALU_OP_SUB; i_cmd_a = 8'h10; i_cmd_b = 8'h01;
      end else if (n == 1) begin
        i_cmd_op = ALU_OP_ADD; i_cmd_a = 8'hFF; i_cmd_b = 8'h02;
      end else begin
        i_cmd_valid = 1'b0;
      end
    end
    repeat (8) tick();
    chk("b2b_gap1", accs[1] - accs[0], 4);
    chk("b2b_gap2", accs[2] - accs[1], 4);
    chk("b2b_count", rsp_q.size(), 3);
    if (rsp_q.size() == 3) begin
      chk("b2b_rsp0", rsp_q[0], 8'h11);
      chk("b2b_rsp1", rsp_q[1], 8'h0F);
      chk("b2b_rsp2", rsp_q[2], 8'h01);
    end

    // random traffic against the model
    stray_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      stub_delay  = $urandom_range(1, 4);
      i_rsp_ready = ($urandom_range(0, 2) != 0);
      i_cmd_valid = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 4))
        0, 1:    i_cmd_op = ALU_OP_ADD;
        2, 3:    i_cmd_op = ALU_OP_SUB;
        default: i_cmd_op = 3'($urandom_range(0, 7));
      endcase
      i_cmd_a = 8'($urandom);
      i_cmd_b = 8'($urandom);
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    repeat (12) tick();
    chk("drain_idle", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Initiator side of the ALU load/valid interface: accepts arithmetic commands over a valid/ready stream and drives the ALU control/load/operand lines.
- Waits for the ALU result pulse, then presents the result on a valid/ready response stream.
- Sits between the instruction decode stage and the 8-bit ALU; only one command is in flight at a time.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- TIMEOUT_CYCLES, 15, WAIT-state cycles before giving up; used only with ALU_TIMEOUT_EN; legal range 2..255.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset: synchronous, active-high
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  issuer can accept a command
- i_cmd_op  in  3  opcode: 001 add, 010 sub
- i_cmd_a  in  DATA_W  operand A
- i_cmd_b  in  DATA_W  operand B
- o_alu_control  out  3  to ALU control input
- o_alu_load  out  1  one-cycle ALU load strobe
- o_alu_din_a  out  DATA_W  to ALU operand A
- o_alu_din_b  out  DATA_W  to ALU operand B
- i_alu_valid  in  1  ALU result strobe
- i_alu_dout  in  DATA_W  ALU result
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer accepts response
- o_rsp_data  out  DATA_W  result
- o_rsp_err  out  1  illegal opcode or timeout
- o_busy  out  1  state != IDLE

Behaviour:
- Reset value of every output is 0, except o_cmd_ready. The FSM resets to IDLE, so o_cmd_ready = 1 in the cycle after reset.
- All outputs are registered or decoded directly from FSM state; no combinational path from any input to any output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid && o_cmd_ready, latch op/a/b.
  - Legal op (001/010): go to ISSUE.
  - Illegal op: go to RESP with data 0x00, err = 1, and never touch the ALU.
- ISSUE:
  - o_alu_load = 1 for exactly one cycle.
  - o_alu_control, o_alu_din_a and o_alu_din_b carry the latched values.
  - Go to WAIT.
- WAIT:
  - On i_alu_valid, capture i_alu_dout into o_rsp_data with err = 0, then go to RESP.
  - o_alu_control, o_alu_din_a and o_alu_din_b hold their values until IDLE.
- RESP:
  - o_rsp_valid = 1; data and err are held stable while i_rsp_ready = 0.
  - On i_rsp_ready, go to IDLE.
  - There is no RESP-to-accept bypass: the next command is accepted at the earliest one cycle after the response handshake.
- Latency: command accepted at edge N → o_alu_load high during cycle N+1 → ALU valid during N+2 → o_rsp_valid high from N+3. Minimum throughput is 1 command per 4 cycles.
- i_alu_valid outside WAIT is ignored and causes no state or output change.
- i_cmd_valid outside IDLE is not accepted (o_cmd_ready = 0).
- Reset mid-operation, in any state: return to IDLE next edge, all outputs 0 except o_cmd_ready, and the in-flight command is discarded.
- Result arithmetic is the ALU's; the issuer does no width extension. Sub wraps modulo 2^DATA_W, e.g. 0x00 - 0x01 = 0xFF.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without i_alu_valid.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with data 0x00, err = 1.
  - If i_alu_valid and the timeout occur in the same cycle, valid wins (err = 0).
- Not defined: no counter. WAIT holds indefinitely until i_alu_valid. o_rsp_err is asserted only for illegal opcodes.

Decomposition:
- Shared package venera_alu_pkg holds:
  - opcode constants ALU_OP_NOP = 3'b000, ALU_OP_ADD = 3'b001, ALU_OP_SUB = 3'b010;
  - the ALU_CTRL_W = 3 width constant;
  - FSM state encoding for the issuer.
- Use these constants in place of literals in the ALU and the issuer.
- One natural sub-module: alu_issuer_timeout, the counter plus expiry compare. It is instantiated only under ALU_TIMEOUT_EN.

Test Plan:
- Add: cmd op=001, a=0x12, b=0x34 with a real ALU attached → o_alu_load is a single pulse at N+1, o_rsp_valid at N+3, data 0x46, err 0.
- Sub wrap and backpressure: op=010, a=0x00, b=0x01, i_rsp_ready held low 5 cycles → data 0xFF stable with valid high for all 5 cycles; o_cmd_ready stays 0 until after the handshake.
- Illegal opcode: op=011, a=0x55 → no o_alu_load pulse; rsp data 0x00, err 1, at N+1.
- Reset mid-op: assert i_reset during WAIT → next cycle IDLE, o_cmd_ready 1, no o_rsp_valid. A stray i_alu_valid afterwards is ignored.
- Timeout (ALU_TIMEOUT_EN, TIMEOUT_CYCLES=4): ALU stub never returns valid → rsp err 1, data 0x00 after 4 WAIT cycles. Without the macro, the same stimulus leaves o_busy high indefinitely.
- Back-to-back: 3 commands with i_cmd_valid always high and i_rsp_ready always high → accepts spaced exactly 4 cycles apart, results delivered in order.
